// File: rtl/nn_calc_sequencer_if.sv
// Bus bundle between the CSR/datapath side and the calculation sequencer.
// The master drives start/abort and observes the sequencer's strobes and
// addresses. The slave is the sequencer itself.
interface nn_calc_sequencer_if #(
  parameter int PIX_W = 11,
  parameter int WGT_W = 14
);
  logic             start_calc;
  logic             abort;
  logic [PIX_W-1:0] pixel_address;
  logic [WGT_W-1:0] weight_address;
  logic             mem_rd;
  logic             mac_en;
  logic             acc_clear;
  logic             result_wen;
  logic [3:0]       result_addr;
  logic             busy;
  logic             done_calc;

  modport master (
    output start_calc, abort,
    input  pixel_address, weight_address, mem_rd, mac_en, acc_clear,
           result_wen, result_addr, busy, done_calc
  );

  modport slave (
    input  start_calc, abort,
    output pixel_address, weight_address, mem_rd, mac_en, acc_clear,
           result_wen, result_addr, busy, done_calc
  );
endinterface

// File: rtl/nn_calc_sequencer.sv
// Sequencer for the MAC datapath. It walks the pixel and weight memories once
// per output neuron, clears the accumulator, and commits each sum to the result
// registers. All outputs are registered from the next-state values.
//
// state  | meaning
// IDLE   | waiting for a rising edge on start_calc
// CLEAR  | one-cycle accumulator clear before a neuron
// FETCH  | issue one pixel/weight read per cycle
// DRAIN  | wait out the SRAM latency so the last MAC lands
// STORE  | write the accumulator to result register <neuron>
// DONE   | one-cycle completion pulse
module nn_calc_sequencer #(
  parameter int N_INPUTS  = 784,
  parameter int N_OUTPUTS = 10,
  parameter int MEM_LAT   = 1,
  parameter int PIX_W     = 11,
  parameter int WGT_W     = 14
) (
  input logic                clk,
  input logic                n_rst,
  nn_calc_sequencer_if.slave bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_FETCH = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_STORE = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam logic [PIX_W-1:0] PIX_LAST  = PIX_W'(N_INPUTS - 1);
  localparam logic [3:0]       NEUR_LAST = 4'(N_OUTPUTS - 1);
  localparam logic [WGT_W-1:0] WGT_STEP  = WGT_W'(N_INPUTS);
  localparam logic [1:0]       LAT_LOAD  = 2'(MEM_LAT - 1);

  logic [2:0]         state_q, state_d;
  logic [PIX_W-1:0]   pix_q, pix_d;
  logic [3:0]         neuron_q, neuron_d;
  logic [WGT_W-1:0]   wbase_q, wbase_d;
  logic [1:0]         lat_q, lat_d;
  logic               start_q;
  logic [MEM_LAT-1:0] vld_q, vld_d;

  logic [PIX_W-1:0]   pixel_address_q, pixel_address_d;
  logic [WGT_W-1:0]   weight_address_q, weight_address_d;
  logic               mem_rd_q, mem_rd_d;
  logic               acc_clear_q, acc_clear_d;
  logic               result_wen_q, result_wen_d;
  logic [3:0]         result_addr_q, result_addr_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic start_edge;
  logic kill;

  assign start_edge = bus.start_calc & ~start_q;
  // Abort only matters once a run is under way; in IDLE it merely blocks a launch.
  assign kill       = bus.abort & (state_q != S_IDLE);

  // Next-state and counter update; weight base accumulates by N_INPUTS per neuron.
  always_comb begin
    state_d  = state_q;
    pix_d    = pix_q;
    neuron_d = neuron_q;
    wbase_d  = wbase_q;
    lat_d    = lat_q;
    if (kill) begin
      state_d  = S_IDLE;
      pix_d    = '0;
      neuron_d = '0;
      wbase_d  = '0;
      lat_d    = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_edge && !bus.abort) begin
            state_d  = S_CLEAR;
            neuron_d = '0;
            wbase_d  = '0;
          end
        end
        S_CLEAR: begin
          state_d = S_FETCH;
          pix_d   = '0;
        end
        S_FETCH: begin
          if (pix_q == PIX_LAST) begin
            state_d = S_DRAIN;
            lat_d   = LAT_LOAD;
          end else begin
            pix_d = pix_q + PIX_W'(1);
          end
        end
        S_DRAIN: begin
          if (lat_q == 2'd0) state_d = S_STORE;
          else               lat_d   = lat_q - 2'd1;
        end
        S_STORE: begin
          if (neuron_q == NEUR_LAST) begin
            state_d = S_DONE;
          end else begin
            state_d  = S_CLEAR;
            neuron_d = neuron_q + 4'd1;
            wbase_d  = wbase_q + WGT_STEP;
          end
        end
        S_DONE: begin
          state_d  = S_IDLE;
          pix_d    = '0;
          neuron_d = '0;
          wbase_d  = '0;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Output decode from the next state so every output leaves a flop.
  always_comb begin
    mem_rd_d         = (state_d == S_FETCH);
    pixel_address_d  = (state_d == S_FETCH) ? pix_d : '0;
    weight_address_d = (state_d == S_FETCH) ? (wbase_d + WGT_W'(pix_d)) : '0;
    acc_clear_d      = (state_d == S_CLEAR);
    result_wen_d     = (state_d == S_STORE);
    result_addr_d    = (state_d == S_STORE) ? neuron_d : '0;
    busy_d           = (state_d != S_IDLE);
    done_d           = (state_d == S_DONE);
  end

  // Valid pipe: mac_en is mem_rd delayed by the SRAM latency; flushed on abort.
  always_comb begin
    vld_d = '0;
    if (!kill) begin
      vld_d[0] = mem_rd_q;
      for (int i = 1; i < MEM_LAT; i++) vld_d[i] = vld_q[i-1];
    end
  end

  // State, counters, start history and registered outputs.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q          <= S_IDLE;
      pix_q            <= '0;
      neuron_q         <= '0;
      wbase_q          <= '0;
      lat_q            <= '0;
      start_q          <= 1'b0;
      vld_q            <= '0;
      pixel_address_q  <= '0;
      weight_address_q <= '0;
      mem_rd_q         <= 1'b0;
      acc_clear_q      <= 1'b0;
      result_wen_q     <= 1'b0;
      result_addr_q    <= '0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      pix_q            <= pix_d;
      neuron_q         <= neuron_d;
      wbase_q          <= wbase_d;
      lat_q            <= lat_d;
      start_q          <= bus.start_calc;
      vld_q            <= vld_d;
      pixel_address_q  <= pixel_address_d;
      weight_address_q <= weight_address_d;
      mem_rd_q         <= mem_rd_d;
      acc_clear_q      <= acc_clear_d;
      result_wen_q     <= result_wen_d;
      result_addr_q    <= result_addr_d;
      busy_q           <= busy_d;
      done_q           <= done_d;
    end
  end

  assign bus.pixel_address  = pixel_address_q;
  assign bus.weight_address = weight_address_q;
  assign bus.mem_rd         = mem_rd_q;
  assign bus.mac_en         = vld_q[MEM_LAT-1];
  assign bus.acc_clear      = acc_clear_q;
  assign bus.result_wen     = result_wen_q;
  assign bus.result_addr    = result_addr_q;
  assign bus.busy           = busy_q;
  assign bus.done_calc      = done_q;

endmodule

// File: tb/tb_nn_calc_sequencer.sv
// Bench for nn_calc_sequencer. Three instances with different geometry share a
// clock and reset; each cycle's outputs are compared with a timeline model that
// derives every strobe from the cycle offset after the start edge.
module tb_nn_calc_sequencer;

  typedef struct packed {
    logic [13:0] wa;
    logic [10:0] pa;
    logic        mem_rd;
    logic        mac_en;
    logic        acc_clear;
    logic        result_wen;
    logic [3:0]  ra;
    logic        busy;
    logic        done;
  } obs_t;

  logic clk;
  logic n_rst;
  logic start_v [3];
  logic abort_v [3];
  obs_t obs [3];

  int checks = 0;
  int errors = 0;

  int     r_macs, r_wens, r_dones, r_done_t, r_last_mac_t, r_last_wen_t;
  longint r_ra_seq;

  nn_calc_sequencer_if #(.PIX_W(11), .WGT_W(14)) if0 ();
  nn_calc_sequencer_if #(.PIX_W(11), .WGT_W(14)) if1 ();
  nn_calc_sequencer_if #(.PIX_W(11), .WGT_W(14)) if2 ();

  nn_calc_sequencer #(.N_INPUTS(4), .N_OUTPUTS(2), .MEM_LAT(1), .PIX_W(11), .WGT_W(14))
    dut0 (.clk(clk), .n_rst(n_rst), .bus(if0));
  nn_calc_sequencer #(.N_INPUTS(5), .N_OUTPUTS(3), .MEM_LAT(3), .PIX_W(11), .WGT_W(14))
    dut1 (.clk(clk), .n_rst(n_rst), .bus(if1));
  nn_calc_sequencer #(.N_INPUTS(784), .N_OUTPUTS(10), .MEM_LAT(1), .PIX_W(11), .WGT_W(14))
    dut2 (.clk(clk), .n_rst(n_rst), .bus(if2));

  assign if0.start_calc = start_v[0];
  assign if0.abort      = abort_v[0];
  assign if1.start_calc = start_v[1];
  assign if1.abort      = abort_v[1];
  assign if2.start_calc = start_v[2];
  assign if2.abort      = abort_v[2];

  assign obs[0] = '{wa: if0.weight_address, pa: if0.pixel_address, mem_rd: if0.mem_rd,
                    mac_en: if0.mac_en, acc_clear: if0.acc_clear, result_wen: if0.result_wen,
                    ra: if0.result_addr, busy: if0.busy, done: if0.done_calc};
  assign obs[1] = '{wa: if1.weight_address, pa: if1.pixel_address, mem_rd: if1.mem_rd,
                    mac_en: if1.mac_en, acc_clear: if1.acc_clear, result_wen: if1.result_wen,
                    ra: if1.result_addr, busy: if1.busy, done: if1.done_calc};
  assign obs[2] = '{wa: if2.weight_address, pa: if2.pixel_address, mem_rd: if2.mem_rd,
                    mac_en: if2.mac_en, acc_clear: if2.acc_clear, result_wen: if2.result_wen,
                    ra: if2.result_addr, busy: if2.busy, done: if2.done_calc};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int ni_of(int d);
    return (d == 0) ? 4 : (d == 1) ? 5 : 784;
  endfunction
  function automatic int no_of(int d);
    return (d == 0) ? 2 : (d == 1) ? 3 : 10;
  endfunction
  function automatic int ml_of(int d);
    return (d == 0) ? 1 : (d == 1) ? 3 : 1;
  endfunction
  function automatic int end_of(int d);
    return no_of(d) * (ni_of(d) + ml_of(d) + 2) + 1;
  endfunction

  // Expected outputs t cycles after the launching edge (t=1 is the clear cycle).
  // Each neuron occupies a slot of clear + N_INPUTS reads + MEM_LAT drain + store.
  function automatic obs_t model(int d, int t, int abort_at);
    obs_t e;
    int ni, ml, p, n, k;
    e  = '0;
    ni = ni_of(d);
    ml = ml_of(d);
    p  = ni + ml + 2;
    if (abort_at > 0 && t > abort_at) return e;
    if (t < 1 || t > end_of(d)) return e;
    e.busy = 1'b1;
    if (t == end_of(d)) begin
      e.done = 1'b1;
      return e;
    end
    n = (t - 1) / p;
    k = (t - 1) % p;
    if (k == 0) e.acc_clear = 1'b1;
    if (k >= 1 && k <= ni) begin
      e.mem_rd = 1'b1;
      e.pa     = 11'(k - 1);
      e.wa     = 14'(n * ni + k - 1);
    end
    if (k >= ml + 1 && k <= ni + ml) e.mac_en = 1'b1;
    if (k == ni + ml + 1) begin
      e.result_wen = 1'b1;
      e.ra         = 4'(n);
    end
    return e;
  endfunction

  function automatic longint ra_expected(int count);
    longint s = 0;
    for (int n = 0; n < count; n++) s = s * 16 + longint'(n);
    return s;
  endfunction

  // One launch on instance d. abort_at>0 asserts abort during that cycle.
  // toggle randomises start_calc while busy; hold keeps it high, else a one-cycle pulse.
  task automatic run_seq(input int d, input int abort_at, input bit toggle, input bit hold,
                         input int tail);
    obs_t e;
    int   limit, last;
    r_macs = 0; r_wens = 0; r_dones = 0; r_done_t = 0;
    r_last_mac_t = 0; r_last_wen_t = 0; r_ra_seq = 0;
    limit = (abort_at > 0) ? abort_at : end_of(d);
    last  = limit + tail;
    @(negedge clk);
    start_v[d] = 1'b1;
    for (int t = 1; t <= last; t++) begin
      @(negedge clk);
      e = model(d, t, abort_at);
      checks++;
      if (obs[d] !== e) begin
        errors++;
        $display("FAIL seq d%0d t=%0d got %h expected %h", d, t, obs[d], e);
      end
      if (obs[d].mac_en === 1'b1) begin r_macs++; r_last_mac_t = t; end
      if (obs[d].result_wen === 1'b1) begin
        r_wens++; r_last_wen_t = t;
        r_ra_seq = r_ra_seq * 16 + longint'(obs[d].ra);
      end
      if (obs[d].done === 1'b1) begin r_dones++; r_done_t = t; end
      abort_v[d] = (abort_at > 0 && t == abort_at);
      if (t <= limit) begin
        if (toggle)    start_v[d] = 1'($urandom_range(0, 1));
        else if (!hold) start_v[d] = 1'b0;
      end
    end
    abort_v[d] = 1'b0;
    start_v[d] = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    for (int d = 0; d < 3; d++) begin start_v[d] = 1'b0; abort_v[d] = 1'b0; end
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (obs[d] !== obs_t'(0)) begin
        errors++;
        $display("FAIL reset_values d%0d got %h expected 0", d, obs[d]);
      end
    end
    n_rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (obs[0] !== obs_t'(0)) begin
      errors++;
      $display("FAIL reset_release_idle got %h expected 0", obs[0]);
    end
  endtask

  task automatic test_small_basic();
    run_seq(0, 0, 1'b0, 1'b0, 4);
    checks++;
    if (r_done_t !== 15) begin errors++; $display("FAIL small_done_t got %0d expected 15", r_done_t); end
    checks++;
    if (r_macs !== 8) begin errors++; $display("FAIL small_macs got %0d expected 8", r_macs); end
    checks++;
    if (r_ra_seq !== ra_expected(2)) begin
      errors++; $display("FAIL small_ra_seq got %h expected %h", r_ra_seq, ra_expected(2));
    end
  endtask

  task automatic test_memlat3();
    run_seq(1, 0, 1'b0, 1'b0, 4);
    checks++;
    if (r_done_t !== end_of(1)) begin
      errors++; $display("FAIL lat3_done_t got %0d expected %0d", r_done_t, end_of(1));
    end
    checks++;
    if (r_last_wen_t !== r_last_mac_t + 1) begin
      errors++; $display("FAIL lat3_wen_after_mac got %0d expected %0d", r_last_wen_t, r_last_mac_t + 1);
    end
    checks++;
    if (r_macs !== 15) begin errors++; $display("FAIL lat3_macs got %0d expected 15", r_macs); end
  endtask

  task automatic test_defaults();
    run_seq(2, 0, 1'b0, 1'b1, 30);
    checks++;
    if (r_done_t !== 7871) begin errors++; $display("FAIL def_done_t got %0d expected 7871", r_done_t); end
    checks++;
    if (r_macs !== 7840) begin errors++; $display("FAIL def_macs got %0d expected 7840", r_macs); end
    checks++;
    if (r_wens !== 10) begin errors++; $display("FAIL def_wens got %0d expected 10", r_wens); end
    checks++;
    if (r_ra_seq !== ra_expected(10)) begin
      errors++; $display("FAIL def_ra_seq got %h expected %h", r_ra_seq, ra_expected(10));
    end
    checks++;
    if (r_dones !== 1) begin errors++; $display("FAIL def_relaunch dones got %0d expected 1", r_dones); end
  endtask

  task automatic test_abort();
    // Neuron 1, pix 2 sits at cycle 1 + 7 + 3.
    run_seq(0, 11, 1'b0, 1'b0, 6);
    checks++;
    if (r_wens !== 1) begin errors++; $display("FAIL abort_wens got %0d expected 1", r_wens); end
    checks++;
    if (r_dones !== 0) begin errors++; $display("FAIL abort_done got %0d expected 0", r_dones); end
    run_seq(0, 0, 1'b0, 1'b0, 3);
    checks++;
    if (r_dones !== 1) begin errors++; $display("FAIL abort_restart got %0d expected 1", r_dones); end
  endtask

  task automatic test_abort_random();
    for (int i = 0; i < 6; i++) begin
      int d, a;
      d = int'($urandom_range(0, 1));
      a = int'($urandom_range(1, end_of(d)));
      run_seq(d, a, 1'b1, 1'b0, 5);
      checks++;
      if (r_dones !== ((a == end_of(d)) ? 1 : 0)) begin
        errors++; $display("FAIL abort_rand d%0d a=%0d dones got %0d", d, a, r_dones);
      end
    end
  endtask

  task automatic test_abort_idle_start();
    @(negedge clk);
    start_v[0] = 1'b1;
    abort_v[0] = 1'b1;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      abort_v[0] = 1'b0;
      checks++;
      if (obs[0] !== obs_t'(0)) begin
        errors++; $display("FAIL abort_idle_start t=%0d got %h expected 0", t, obs[0]);
      end
    end
    start_v[0] = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back_toggle();
    for (int d = 0; d < 2; d++) begin
      run_seq(d, 0, 1'b1, 1'b0, 4);
      checks++;
      if (r_dones !== 1) begin errors++; $display("FAIL toggle_dones d%0d got %0d expected 1", d, r_dones); end
      checks++;
      if (r_ra_seq !== ra_expected(no_of(d))) begin
        errors++; $display("FAIL toggle_ra d%0d got %h expected %h", d, r_ra_seq, ra_expected(no_of(d)));
      end
    end
  endtask

  task automatic test_reset_mid();
    obs_t e;
    @(negedge clk);
    start_v[0] = 1'b1;
    for (int t = 1; t <= 4; t++) begin
      @(negedge clk);
      start_v[0] = 1'b0;
      e = model(0, t, 0);
      checks++;
      if (obs[0] !== e) begin
        errors++; $display("FAIL rstmid_pre t=%0d got %h expected %h", t, obs[0], e);
      end
    end
    #2 n_rst = 1'b0;
    #1;
    checks++;
    if (obs[0] !== obs_t'(0)) begin
      errors++; $display("FAIL rstmid_async got %h expected 0", obs[0]);
    end
    @(negedge clk);
    n_rst = 1'b1;
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      checks++;
      if (obs[0] !== obs_t'(0)) begin
        errors++; $display("FAIL rstmid_quiet t=%0d got %h expected 0", t, obs[0]);
      end
    end
    run_seq(0, 0, 1'b0, 1'b0, 3);
    checks++;
    if (r_dones !== 1) begin errors++; $display("FAIL rstmid_restart got %0d expected 1", r_dones); end
  endtask

  initial begin
    test_reset();
    test_small_basic();
    test_memlat3();
    test_abort();
    test_abort_idle_start();
    test_abort_random();
    test_back_to_back_toggle();
    test_reset_mid();
    test_defaults();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
